// File: rtl/alu_pkg.sv
// Shared 74181 function-select codes and the nibble sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b1001;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0110;  // same select as OP_SUB, used with M=1
  localparam logic [3:0] OP_AND = 4'b1011;
  localparam logic [3:0] OP_OR  = 4'b1110;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFin  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu74181.sv
// 4-bit 74181 ALU slice, active-high data, active-low carry in/out. Purely combinational.
module alu74181 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cn,
  output logic [3:0] f,
  output logic       cn4,
  output logic       eqv,
  output logic       g,
  output logic       p
);

  logic [3:0] gen;
  logic [3:0] prop;
  logic [3:0] half;
  logic [4:0] c;

  always_comb begin
    gen  = (a & b & {4{s[3]}}) | (a & ~b & {4{s[2]}});
    prop = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    half = prop & ~gen;
    // Internal carries are active-high; the pins use the inverted sense.
    c[0] = ~cn;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = gen[i] | (prop[i] & c[i]);
    end
    f   = m ? ~half : (half ^ c[3:0]);
    cn4 = ~c[4];
    eqv = &f;
    g   = ~(gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1]) |
            (prop[3] & prop[2] & prop[1] & gen[0]));
    p   = ~(&prop);
  end

endmodule

// File: rtl/alu_nibble_seq.sv
// Runs WIDTH-bit 74181 operations through one 4-bit slice, one nibble per clock, LSB first,
// chaining the slice carry between cycles and accumulating zero / A=B flags.
module alu_nibble_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op_s,
  input  logic             op_m,
  input  logic             op_cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             eqv_all
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIB - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : gen_width_check
    $error("alu_nibble_seq: WIDTH must be a multiple of 4 and at least 4");
  end

  seq_state_e state_q, state_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic load, step, finish;

  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [3:0]       s_q;
  logic             m_q;
  logic             cy_q;
  logic             zacc_q, eacc_q;
  logic [IdxW-1:0]  idx_q;
  logic             carry_out_q, zero_q, eqv_all_q;

  logic [IdxW+1:0]  nib_lsb;
  logic [3:0]       slice_f;
  logic             slice_cout, slice_eqv;
  logic             unused_slice_g, unused_slice_p;

  assign nib_lsb = {idx_q, 2'b00};

  alu74181 u_slice (
    .a   (a_q[nib_lsb +: 4]),
    .b   (b_q[nib_lsb +: 4]),
    .s   (s_q),
    .m   (m_q),
    .cn  (cy_q),
    .f   (slice_f),
    .cn4 (slice_cout),
    .eqv (slice_eqv),
    .g   (unused_slice_g),
    .p   (unused_slice_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // A start coinciding with the done pulse is dropped, not queued.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !done_q) begin
          load    = 1'b1;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        step = 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StFin;
        end
      end
      StFin: begin
        finish  = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      m_q         <= 1'b0;
      cy_q        <= 1'b0;
      zacc_q      <= 1'b0;
      eacc_q      <= 1'b0;
      idx_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
      eqv_all_q   <= 1'b0;
    end else begin
      if (load) begin
        a_q    <= a;
        b_q    <= b;
        s_q    <= op_s;
        m_q    <= op_m;
        cy_q   <= op_cin;
        idx_q  <= '0;
        zacc_q <= 1'b1;
        eacc_q <= 1'b1;
      end
      if (step) begin
        result_q[nib_lsb +: 4] <= slice_f;
        cy_q   <= slice_cout;
        zacc_q <= zacc_q & (slice_f == 4'h0);
        eacc_q <= eacc_q & slice_eqv;
        idx_q  <= idx_q + 1'b1;
      end
      if (finish) begin
        carry_out_q <= cy_q;
        zero_q      <= zacc_q;
        eqv_all_q   <= eacc_q;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign zero      = zero_q;
  assign eqv_all   = eqv_all_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Self-checking bench for alu_nibble_seq: directed cases plus randomized ops against a
// word-level 74181 model.
module tb_alu_nibble_seq;
  import alu_pkg::*;

  localparam int unsigned W   = 16;
  localparam int unsigned NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op_s = 4'h0;
  logic         op_m = 1'b0;
  logic         op_cin = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, carry_out, zero, eqv_all;
  logic [W-1:0] result;

  int checks = 0;
  int failures = 0;

  alu_nibble_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_s      (op_s),
    .op_m      (op_m),
    .op_cin    (op_cin),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .zero      (zero),
    .eqv_all   (eqv_all)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word-level datasheet behaviour: arithmetic is "X plus Y plus carry" per select row,
  // logic mode is the bitwise function; carry is reported active-low.
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic [3:0] s, input logic m, input logic cin,
                                output logic [W-1:0] r, output logic co,
                                output logic z, output logic e);
    logic [W-1:0] lhs, rhs, lres;
    logic [W:0]   sum;
    lhs  = x;
    rhs  = y;
    lres = ~(x ^ y);
    case (s)
      4'b1001: begin lhs = x;      rhs = y;  lres = ~(x ^ y); end  // A plus B
      4'b0110: begin lhs = x;      rhs = ~y; lres = x ^ y;    end  // A minus B minus 1
      4'b1011: begin lhs = x & y;  rhs = '1; lres = x & y;    end  // AB minus 1
      4'b1110: begin lhs = x | ~y; rhs = x;  lres = x | y;    end  // (A+~B) plus A
      default: ;
    endcase
    sum = {1'b0, lhs} + {1'b0, rhs} + ((cin == 1'b0) ? (W+1)'(1) : (W+1)'(0));
    r   = m ? lres : sum[W-1:0];
    co  = ~sum[W];
    z   = (r == '0);
    e   = &r;
  endfunction

  // Issue one operation from an idle, post-edge point and check the complete transaction.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic [3:0] ts, input logic tm, input logic tc,
                        input bit scramble, input bit extra_starts);
    logic [W-1:0] er;
    logic         eco, ez, ee;
    int           cyc;
    bit           got;
    int           extra_done;
    model(ta, tb, ts, tm, tc, er, eco, ez, ee);
    a = ta; b = tb; op_s = ts; op_m = tm; op_cin = tc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_run"}, busy, 1);
    if (scramble) begin
      a = W'($urandom); b = W'($urandom); op_s = 4'($urandom); op_m = ~tm; op_cin = ~tc;
    end
    cyc = 0;
    got = 0;
    while (!got && cyc < 20) begin
      if (extra_starts && (cyc == 1 || cyc == 3)) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (done) got = 1;
    end
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_latency"}, cyc, NIB + 1);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_result"}, result, er);
    check({tag, "_carry"}, carry_out, eco);
    check({tag, "_zero"}, zero, ez);
    check({tag, "_eqv"}, eqv_all, ee);
    if (extra_starts) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_done_pulse"}, done, 0);
    if (extra_starts) begin
      check({tag, "_start_at_done_ignored"}, busy, 0);
      extra_done = 0;
      for (int i = 0; i < NIB + 3; i++) begin
        @(posedge clk); #1;
        if (done) extra_done++;
      end
      check({tag, "_no_extra_done"}, extra_done, 0);
      check({tag, "_result_hold"}, result, er);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [3:0]   rs;
    logic         rm, rc;
    int           sel, cyc;
    bit           seen_done;

    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_carry", carry_out, 0);
    check("rst_zero", zero, 0);
    check("rst_eqv", eqv_all, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add", 16'h00FF, 16'h0001, OP_ADD, 1'b0, 1'b1, 0, 0);
    check("add_result_lit", result, 16'h0100);
    check("add_carry_lit", carry_out, 1);

    // Abort an add mid-flight with async reset; no done may follow.
    a = 16'h1111; b = 16'h2222; op_s = OP_ADD; op_m = 1'b0; op_cin = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_result", result, 0);
    check("arst_carry", carry_out, 0);
    check("arst_done", done, 0);
    seen_done = 0;
    for (cyc = 0; cyc < 3; cyc++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1;
    end
    rst_n = 1'b1;
    for (cyc = 0; cyc < NIB + 3; cyc++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1;
    end
    check("arst_no_done", seen_done, 0);

    run_op("add_post_rst", 16'h1234, 16'h4321, OP_ADD, 1'b0, 1'b1, 0, 0);
    run_op("add_ovf", 16'hFFFF, 16'h0001, OP_ADD, 1'b0, 1'b1, 0, 0);
    check("add_ovf_lit", result, 16'h0000);
    run_op("cmp_eq", 16'h1234, 16'h1234, OP_SUB, 1'b0, 1'b0, 0, 0);
    check("cmp_eq_zero_lit", zero, 1);
    run_op("cmp_eq_m1", 16'h1234, 16'h1234, OP_SUB, 1'b0, 1'b1, 0, 0);
    check("cmp_eq_m1_lit", result, 16'hFFFF);
    check("cmp_eq_m1_eqv_lit", eqv_all, 1);
    run_op("xor", 16'hF0F0, 16'hFF00, OP_XOR, 1'b1, 1'b1, 1, 0);
    check("xor_lit", result, 16'h0FF0);
    run_op("busy_start", 16'hA5C3, 16'h0F0F, OP_AND, 1'b1, 1'b1, 0, 1);

    for (int n = 0; n < 40; n++) begin
      ra  = W'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      sel = $urandom_range(0, 4);
      case (sel)
        0:       begin rs = OP_ADD; rm = 1'b0; end
        1:       begin rs = OP_SUB; rm = 1'b0; end
        2:       begin rs = OP_XOR; rm = 1'b1; end
        3:       begin rs = OP_AND; rm = 1'b1; end
        default: begin rs = OP_OR;  rm = 1'b1; end
      endcase
      rc = 1'($urandom);
      run_op($sformatf("rand%0d", n), ra, rb, rs, rm, rc, bit'($urandom), n % 7 == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
